cam_lookup_ctrl: RTL and testbench
==================================

CAM_LOOKUP_CTRL -- requirements
Module: cam_lookup_ctrl

Interface
REQ-001 The block SHALL have parameter ARRAY_WIDTH_LOG2, default 5, giving a key width KW = 2**ARRAY_WIDTH_LOG2.
REQ-002 The block SHALL have parameter ARRAY_SIZE_LOG2, default 5, giving an entry count N = 2**ARRAY_SIZE_LOG2 and an index width IW = ARRAY_SIZE_LOG2.
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-004 Port list:
- clk  in  1  clock.
- reset_i  in  1  async active-low reset.
- req_valid_i  in  1  request key valid.
- req_ready_o  out  1  block can accept a request.
- req_key_i  in  KW  key to look up or insert.
- resp_valid_o  out  1  response valid.
- resp_ready_i  in  1  consumer accepts response.
- resp_hit_o  out  1  key was already present.
- resp_index_o  out  IW  CAM index that holds the key.
- resp_evict_o  out  1  miss overwrote a previously valid entry.
- cam_search_o  out  1  CAM search strobe.
- cam_search_data_o  out  KW  CAM search key.
- cam_search_valid_i  in  1  CAM hit flag, combinational in the search cycle.
- cam_search_index_i  in  IW  CAM hit index, combinational in the search cycle.
- cam_write_o  out  1  CAM write strobe.
- cam_write_index_o  out  IW  CAM write index.
- cam_write_data_o  out  KW  CAM write data.
- hit_count_o  out  16  saturating hit counter.
- miss_count_o  out  16  saturating miss counter.

Function
REQ-005 The block SHALL implement the FSM states IDLE, SEARCH, WRITE and RESP.
REQ-006 In IDLE, req_ready_o SHALL be 1; in every other state it SHALL be 0.
REQ-007 In IDLE, req_valid_i=1 SHALL capture req_key_i into the key register and move the FSM to SEARCH at that clock edge.
REQ-008 In SEARCH, cam_search_o SHALL be 1 for exactly one cycle, and cam_search_data_o SHALL equal the captured key.
REQ-009 At the clock edge that ends SEARCH, the block SHALL sample cam_search_valid_i and cam_search_index_i:
- on a hit, it SHALL latch hit=1 and index=cam_search_index_i, then go to RESP;
- on a miss, it SHALL go to WRITE.
REQ-010 In WRITE, the block SHALL assert cam_write_o for exactly one cycle, with cam_write_index_o = alloc_ptr and cam_write_data_o = the captured key.
REQ-011 At the edge that ends WRITE, the block SHALL:
- latch hit=0 and index=alloc_ptr;
- latch evict=1 if fill_count == N, otherwise evict=0;
- advance alloc_ptr by 1 modulo N (N-1 wraps to 0);
- increment fill_count, saturating at N;
- go to RESP.
REQ-012 In RESP, resp_valid_o SHALL be 1, and resp_hit_o, resp_index_o and resp_evict_o SHALL hold stable until resp_ready_i=1.
REQ-013 A RESP cycle with resp_ready_i=1 SHALL return the FSM to IDLE at that edge; there is no IDLE bypass, so back-to-back requests are spaced by at least one IDLE cycle.
REQ-014 Latency from the accept edge SHALL be:
- hit: resp_valid_o high 2 cycles later;
- miss: resp_valid_o high 3 cycles later.
REQ-015 Outside RESP, resp_valid_o, resp_hit_o, resp_evict_o and resp_index_o SHALL be 0.
REQ-016 cam_search_data_o and cam_write_data_o SHALL be 0 outside SEARCH and WRITE respectively.
REQ-017 hit_count_o SHALL increment by 1 at each SEARCH-hit edge, and miss_count_o at each SEARCH-miss edge; both SHALL saturate at 16'hFFFF.
REQ-018 cam_search_o and cam_write_o SHALL never both be 1 in the same cycle.
REQ-019 The replacement policy SHALL be strict round-robin over alloc_ptr; hit entries are never reordered.

Reset
REQ-020 reset_i=0 SHALL immediately, without waiting for clk, force:
- FSM = IDLE;
- alloc_ptr = 0, fill_count = 0;
- hit_count_o = 0, miss_count_o = 0;
- all strobes and response outputs = 0;
- req_ready_o = 1.
REQ-021 Reset asserted mid-transaction SHALL abandon that transaction with no CAM write and no response.
REQ-022 After reset_i rises, the first request SHALL be accepted on the first clock edge with req_valid_i=1.

Verification
REQ-023 Reset check: hold reset_i=0 for 3 cycles -> req_ready_o=1, all other outputs 0, hit_count_o=0 and miss_count_o=0.
REQ-024 First miss: request key 32'hDEADBEEF with the CAM model reporting a miss -> cam_write_o pulse at index 0 with data 32'hDEADBEEF; resp_hit_o=0, resp_index_o=0, resp_evict_o=0 at accept+3; miss_count_o=1.
REQ-025 Hit: request 32'hDEADBEEF again with the CAM returning a hit at index 0 -> no cam_write_o; resp_hit_o=1, resp_index_o=0 at accept+2; hit_count_o=1.
REQ-026 Wrap and evict: 33 distinct-key misses -> writes to indices 0..31, then index 0 again; the 33rd response has resp_evict_o=1 and resp_index_o=0.
REQ-027 Backpressure: hold resp_ready_i=0 for 5 cycles during RESP -> response fields stable and req_ready_o=0 throughout; IDLE is entered one edge after resp_ready_i=1.
REQ-028 Mid-operation reset: drop reset_i during WRITE -> cam_write_o falls with no clock edge, alloc_ptr=0, and no response is issued.

Source files
------------

// File: rtl/cam_lookup_ctrl.sv
// cam_lookup_ctrl: look-up-or-insert controller in front of an external CAM.
// A request key is searched. A hit returns the CAM index. A miss writes the
// key into the next round-robin slot and reports whether that slot was
// already occupied (eviction).
module cam_lookup_ctrl #(
  parameter int ARRAY_WIDTH_LOG2 = 5,
  parameter int ARRAY_SIZE_LOG2  = 5
) (
  input  logic                                clk,
  input  logic                                reset_i,
  input  logic                                req_valid_i,
  output logic                                req_ready_o,
  input  logic [(2**ARRAY_WIDTH_LOG2)-1:0]    req_key_i,
  output logic                                resp_valid_o,
  input  logic                                resp_ready_i,
  output logic                                resp_hit_o,
  output logic [ARRAY_SIZE_LOG2-1:0]          resp_index_o,
  output logic                                resp_evict_o,
  output logic                                cam_search_o,
  output logic [(2**ARRAY_WIDTH_LOG2)-1:0]    cam_search_data_o,
  input  logic                                cam_search_valid_i,
  input  logic [ARRAY_SIZE_LOG2-1:0]          cam_search_index_i,
  output logic                                cam_write_o,
  output logic [ARRAY_SIZE_LOG2-1:0]          cam_write_index_o,
  output logic [(2**ARRAY_WIDTH_LOG2)-1:0]    cam_write_data_o,
  output logic [15:0]                         hit_count_o,
  output logic [15:0]                         miss_count_o
);

  localparam int KW = 2 ** ARRAY_WIDTH_LOG2;
  localparam int IW = ARRAY_SIZE_LOG2;
  localparam int N  = 2 ** ARRAY_SIZE_LOG2;

  // fill_count needs one extra bit so it can hold N itself
  localparam logic [IW:0]   FILL_FULL = N[IW:0];
  localparam logic [IW:0]   FILL_ONE  = 1;
  localparam logic [IW-1:0] PTR_ONE   = 1;
  localparam logic [15:0]   CNT_MAX   = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    WRITE  = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t        state;
  logic [KW-1:0] key;
  logic [IW-1:0] alloc_ptr;
  logic [IW:0]   fill_count;

  // Controller FSM; every output is a flop so reset clears it at once
  always_ff @(posedge clk or negedge reset_i) begin
    if (!reset_i) begin
      state             <= IDLE;
      key               <= '0;
      alloc_ptr         <= '0;
      fill_count        <= '0;
      hit_count_o       <= '0;
      miss_count_o      <= '0;
      req_ready_o       <= 1'b1;
      resp_valid_o      <= 1'b0;
      resp_hit_o        <= 1'b0;
      resp_index_o      <= '0;
      resp_evict_o      <= 1'b0;
      cam_search_o      <= 1'b0;
      cam_search_data_o <= '0;
      cam_write_o       <= 1'b0;
      cam_write_index_o <= '0;
      cam_write_data_o  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid_i) begin
            key               <= req_key_i;
            req_ready_o       <= 1'b0;
            cam_search_o      <= 1'b1;
            cam_search_data_o <= req_key_i;
            state             <= SEARCH;
          end
        end

        SEARCH: begin
          cam_search_o      <= 1'b0;
          cam_search_data_o <= '0;
          if (cam_search_valid_i) begin
            // Hit: answer directly with the index the CAM reported
            if (hit_count_o != CNT_MAX) begin
              hit_count_o <= hit_count_o + 16'd1;
            end
            resp_valid_o <= 1'b1;
            resp_hit_o   <= 1'b1;
            resp_index_o <= cam_search_index_i;
            resp_evict_o <= 1'b0;
            state        <= RESP;
          end else begin
            // Miss: insert the key at the round-robin slot
            if (miss_count_o != CNT_MAX) begin
              miss_count_o <= miss_count_o + 16'd1;
            end
            cam_write_o       <= 1'b1;
            cam_write_index_o <= alloc_ptr;
            cam_write_data_o  <= key;
            state             <= WRITE;
          end
        end

        WRITE: begin
          cam_write_o       <= 1'b0;
          cam_write_index_o <= '0;
          cam_write_data_o  <= '0;
          resp_valid_o      <= 1'b1;
          resp_hit_o        <= 1'b0;
          resp_index_o      <= alloc_ptr;
          // Slot was occupied once every entry has been written at least once
          resp_evict_o      <= (fill_count == FILL_FULL);
          // IW-bit pointer wraps N-1 -> 0 naturally
          alloc_ptr         <= alloc_ptr + PTR_ONE;
          if (fill_count != FILL_FULL) begin
            fill_count <= fill_count + FILL_ONE;
          end
          state <= RESP;
        end

        RESP: begin
          if (resp_ready_i) begin
            resp_valid_o <= 1'b0;
            resp_hit_o   <= 1'b0;
            resp_index_o <= '0;
            resp_evict_o <= 1'b0;
            req_ready_o  <= 1'b1;
            state        <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cam_lookup_ctrl.sv
// Directed testbench for cam_lookup_ctrl (KW = 32, N = 32).
module tb_cam_lookup_ctrl;

  logic        clk;
  logic        reset_i;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [31:0] req_key_i;
  logic        resp_valid_o;
  logic        resp_ready_i;
  logic        resp_hit_o;
  logic [4:0]  resp_index_o;
  logic        resp_evict_o;
  logic        cam_search_o;
  logic [31:0] cam_search_data_o;
  logic        cam_search_valid_i;
  logic [4:0]  cam_search_index_i;
  logic        cam_write_o;
  logic [4:0]  cam_write_index_o;
  logic [31:0] cam_write_data_o;
  logic [15:0] hit_count_o;
  logic [15:0] miss_count_o;

  int n_asserts = 0;
  int n_fail    = 0;

  cam_lookup_ctrl #(
    .ARRAY_WIDTH_LOG2(5),
    .ARRAY_SIZE_LOG2 (5)
  ) dut (
    .clk               (clk),
    .reset_i           (reset_i),
    .req_valid_i       (req_valid_i),
    .req_ready_o       (req_ready_o),
    .req_key_i         (req_key_i),
    .resp_valid_o      (resp_valid_o),
    .resp_ready_i      (resp_ready_i),
    .resp_hit_o        (resp_hit_o),
    .resp_index_o      (resp_index_o),
    .resp_evict_o      (resp_evict_o),
    .cam_search_o      (cam_search_o),
    .cam_search_data_o (cam_search_data_o),
    .cam_search_valid_i(cam_search_valid_i),
    .cam_search_index_i(cam_search_index_i),
    .cam_write_o       (cam_write_o),
    .cam_write_index_o (cam_write_index_o),
    .cam_write_data_o  (cam_write_data_o),
    .hit_count_o       (hit_count_o),
    .miss_count_o      (miss_count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard bound on total run time
  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000ns");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // All outputs in their idle/reset values
  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_req_ready"}, 32'(req_ready_o), 32'd1);
    chk({tag, "_resp_valid"}, 32'(resp_valid_o), 32'd0);
    chk({tag, "_resp_hit"}, 32'(resp_hit_o), 32'd0);
    chk({tag, "_resp_index"}, 32'(resp_index_o), 32'd0);
    chk({tag, "_resp_evict"}, 32'(resp_evict_o), 32'd0);
    chk({tag, "_search"}, 32'(cam_search_o), 32'd0);
    chk({tag, "_search_data"}, cam_search_data_o, 32'd0);
    chk({tag, "_write"}, 32'(cam_write_o), 32'd0);
    chk({tag, "_write_index"}, 32'(cam_write_index_o), 32'd0);
    chk({tag, "_write_data"}, cam_write_data_o, 32'd0);
  endtask

  // One full request/response transaction with hand-supplied expectations.
  // Outputs are sampled 1ns after each rising edge.
  task automatic do_req(input string tag, input logic [31:0] key, input logic hit,
                        input logic [4:0] cam_idx, input logic [4:0] exp_index,
                        input logic exp_evict, input int hold);
    chk({tag, "_ready_before"}, 32'(req_ready_o), 32'd1);
    req_valid_i        = 1'b1;
    req_key_i          = key;
    cam_search_valid_i = hit;
    cam_search_index_i = cam_idx;
    @(posedge clk); #1;
    // accept edge passed: SEARCH cycle
    req_valid_i = 1'b0;
    req_key_i   = '0;
    chk({tag, "_search_strobe"}, 32'(cam_search_o), 32'd1);
    chk({tag, "_search_data"}, cam_search_data_o, key);
    chk({tag, "_ready_search"}, 32'(req_ready_o), 32'd0);
    chk({tag, "_no_write_search"}, 32'(cam_write_o), 32'd0);
    chk({tag, "_no_resp_search"}, 32'(resp_valid_o), 32'd0);
    @(posedge clk); #1;
    chk({tag, "_search_drop"}, 32'(cam_search_o), 32'd0);
    chk({tag, "_search_data_zero"}, cam_search_data_o, 32'd0);
    if (!hit) begin
      chk({tag, "_write_strobe"}, 32'(cam_write_o), 32'd1);
      chk({tag, "_write_index"}, 32'(cam_write_index_o), 32'(exp_index));
      chk({tag, "_write_data"}, cam_write_data_o, key);
      chk({tag, "_no_resp_write"}, 32'(resp_valid_o), 32'd0);
      @(posedge clk); #1;
      chk({tag, "_write_drop"}, 32'(cam_write_o), 32'd0);
      chk({tag, "_write_data_zero"}, cam_write_data_o, 32'd0);
    end else begin
      chk({tag, "_no_write_hit"}, 32'(cam_write_o), 32'd0);
    end
    chk({tag, "_resp_valid"}, 32'(resp_valid_o), 32'd1);
    chk({tag, "_resp_hit"}, 32'(resp_hit_o), 32'(hit));
    chk({tag, "_resp_index"}, 32'(resp_index_o), 32'(exp_index));
    chk({tag, "_resp_evict"}, 32'(resp_evict_o), 32'(exp_evict));
    chk({tag, "_ready_resp"}, 32'(req_ready_o), 32'd0);
    cam_search_valid_i = 1'b0;
    cam_search_index_i = '0;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk({tag, "_hold_valid"}, 32'(resp_valid_o), 32'd1);
      chk({tag, "_hold_hit"}, 32'(resp_hit_o), 32'(hit));
      chk({tag, "_hold_index"}, 32'(resp_index_o), 32'(exp_index));
      chk({tag, "_hold_evict"}, 32'(resp_evict_o), 32'(exp_evict));
      chk({tag, "_hold_ready"}, 32'(req_ready_o), 32'd0);
    end
    resp_ready_i = 1'b1;
    @(posedge clk); #1;
    resp_ready_i = 1'b0;
    chk({tag, "_resp_done"}, 32'(resp_valid_o), 32'd0);
    chk({tag, "_resp_index_zero"}, 32'(resp_index_o), 32'd0);
    chk({tag, "_ready_after"}, 32'(req_ready_o), 32'd1);
    $display("tx %s key=%h hit=%0d index=%0d evict=%0d hits=%0d misses=%0d",
             tag, key, hit, exp_index, exp_evict, hit_count_o, miss_count_o);
  endtask

  initial begin
    reset_i            = 1'b0;
    req_valid_i        = 1'b0;
    req_key_i          = '0;
    resp_ready_i       = 1'b0;
    cam_search_valid_i = 1'b0;
    cam_search_index_i = '0;

    // Reset held for 3 cycles
    repeat (3) @(posedge clk);
    #1;
    chk_idle_outputs("reset");
    chk("reset_hits", 32'(hit_count_o), 32'd0);
    chk("reset_misses", 32'(miss_count_o), 32'd0);
    reset_i = 1'b1;

    // First miss lands in slot 0
    do_req("first_miss", 32'hDEADBEEF, 1'b0, 5'd0, 5'd0, 1'b0, 0);
    chk("first_miss_count", 32'(miss_count_o), 32'd1);
    chk("first_miss_hits", 32'(hit_count_o), 32'd0);

    // Same key again, CAM reports hit at 0
    do_req("hit", 32'hDEADBEEF, 1'b1, 5'd0, 5'd0, 1'b0, 0);
    chk("hit_count", 32'(hit_count_o), 32'd1);
    chk("hit_misses", 32'(miss_count_o), 32'd1);

    // Hit at a non-zero index
    do_req("hit7", 32'h12345678, 1'b1, 5'd7, 5'd7, 1'b0, 0);
    chk("hit7_count", 32'(hit_count_o), 32'd2);

    // Fresh reset, then 33 distinct misses: slots 0..31 then 0 with eviction
    @(posedge clk); #3;
    reset_i = 1'b0;
    #1;
    chk("rst2_hits", 32'(hit_count_o), 32'd0);
    chk("rst2_misses", 32'(miss_count_o), 32'd0);
    @(posedge clk); #1;
    reset_i = 1'b1;
    for (int i = 0; i < 33; i++) begin
      do_req($sformatf("wrap%0d", i), 32'hA5000000 + 32'(i), 1'b0, 5'd0,
             5'(i % 32), (i == 32), 0);
    end
    chk("wrap_misses", 32'(miss_count_o), 32'd33);
    chk("wrap_hits", 32'(hit_count_o), 32'd0);

    // Slot 1 is next and is also an eviction now
    do_req("wrap_next", 32'hA5000100, 1'b0, 5'd0, 5'd1, 1'b1, 0);

    // Backpressure: response held for 5 cycles
    do_req("bp", 32'hCAFEF00D, 1'b1, 5'd5, 5'd5, 1'b0, 5);
    chk("bp_hits", 32'(hit_count_o), 32'd1);

    // Mid-WRITE reset: start a miss and drop reset between edges
    req_valid_i        = 1'b1;
    req_key_i          = 32'h0BADF00D;
    cam_search_valid_i = 1'b0;
    @(posedge clk); #1;
    req_valid_i = 1'b0;
    req_key_i   = '0;
    @(posedge clk); #1;
    chk("midrst_write_before", 32'(cam_write_o), 32'd1);
    chk("midrst_write_index_before", 32'(cam_write_index_o), 32'd2);
    #2;
    reset_i = 1'b0;
    #1;
    // Still between edges: everything must have cleared already
    chk_idle_outputs("midrst");
    chk("midrst_hits", 32'(hit_count_o), 32'd0);
    chk("midrst_misses", 32'(miss_count_o), 32'd0);
    @(posedge clk); #1;
    reset_i = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      chk("midrst_no_resp", 32'(resp_valid_o), 32'd0);
      chk("midrst_no_write", 32'(cam_write_o), 32'd0);
    end
    // Allocation restarts at slot 0 without eviction
    do_req("after_rst", 32'h11112222, 1'b0, 5'd0, 5'd0, 1'b0, 0);
    chk("after_rst_misses", 32'(miss_count_o), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
